// File: rtl/psum_tile_accumulator_if.sv
// Handshake bundle between the systolic array, the tile accumulator
// and the result memory: the upstream partial-sum row channel plus the
// downstream finished-row channel.
interface psum_tile_accumulator_if #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8
);
    logic                      row_valid;
    logic [WIDTH*DATA_W-1:0]   row_data;
    logic                      row_ready;
    logic                      out_valid;
    logic [WIDTH*ACC_W-1:0]    out_data;
    logic [ADDR_W-1:0]         out_addr;
    logic                      out_ready;
    logic                      tile_done;

    // Environment side: supplies psum rows and result-memory readiness.
    modport master (
        output row_valid, row_data, out_ready,
        input  row_ready, out_valid, out_data, out_addr, tile_done
    );

    // Accumulator side.
    modport slave (
        input  row_valid, row_data, out_ready,
        output row_ready, out_valid, out_data, out_addr, tile_done
    );
endinterface

// File: rtl/psum_tile_accumulator.sv
// Output-side stage of the tiled systolic engine. Accumulates psum rows
// over all K-tiles of an output tile into a WIDTH x WIDTH buffer, then
// drains the finished tile row by row to the result memory while holding
// the array off with row_ready low.
module psum_tile_accumulator #(
    parameter int WIDTH   = 4,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int K_TILES = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    psum_tile_accumulator_if.slave bus
);

    localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [RW-1:0]            r_rowCnt;
    logic [RW-1:0]            r_drainCnt;
    logic [KW-1:0]            r_kCnt;
    logic [ADDR_W-1:0]        r_tileBase;
    logic                     r_tileDone;
    logic signed [ACC_W-1:0]  r_buf [WIDTH][WIDTH];

    logic signed [ACC_W-1:0]  w_ext [WIDTH];
    logic                     w_rowAccept;
    logic                     w_outFire;
    logic                     w_rowWrap;
    logic                     w_lastK;
    logic                     w_drainWrap;

    assign w_rowAccept = bus.row_valid && (r_state == ACCUM);
    assign w_outFire   = bus.out_ready && (r_state == DRAIN);
    assign w_rowWrap   = (r_rowCnt == RW'(WIDTH - 1));
    assign w_lastK     = (r_kCnt == KW'(K_TILES - 1));
    assign w_drainWrap = (r_drainCnt == RW'(WIDTH - 1));

    // Sign-extend each incoming psum element to accumulator width.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            w_ext[j] = ACC_W'(signed'(bus.row_data[j*DATA_W +: DATA_W]));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leave ACCUM on the last row of the last K-tile, leave DRAIN on the final row handshake.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ACCUM:   if (w_rowAccept && w_rowWrap && w_lastK) w_nextState = DRAIN;
            DRAIN:   if (w_outFire && w_drainWrap)            w_nextState = ACCUM;
            default: w_nextState = ACCUM;
        endcase
    end

    // Outputs come only from registered state so the handshake inputs never reach them.
    always_comb begin
        bus.row_ready = (r_state == ACCUM);
        bus.out_valid = (r_state == DRAIN);
        bus.out_addr  = r_tileBase + ADDR_W'(r_drainCnt);
        bus.tile_done = r_tileDone;
        bus.out_data  = '0;
        if (r_state == DRAIN) begin
            for (int j = 0; j < WIDTH; j++) begin
                bus.out_data[j*ACC_W +: ACC_W] = r_buf[r_drainCnt][j];
            end
        end
    end

    // Row/K-tile/drain counters, tile base address and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rowCnt   <= '0;
            r_kCnt     <= '0;
            r_drainCnt <= '0;
            r_tileBase <= '0;
            r_tileDone <= 1'b0;
        end else begin
            r_tileDone <= w_outFire && w_drainWrap;
            if (w_rowAccept) begin
                if (w_rowWrap) begin
                    r_rowCnt <= '0;
                    r_kCnt   <= w_lastK ? '0 : r_kCnt + KW'(1);
                end else begin
                    r_rowCnt <= r_rowCnt + RW'(1);
                end
            end
            if (w_outFire) begin
                if (w_drainWrap) begin
                    r_drainCnt <= '0;
                    r_tileBase <= r_tileBase + ADDR_W'(WIDTH);
                end else begin
                    r_drainCnt <= r_drainCnt + RW'(1);
                end
            end
        end
    end

    // Buffer update: the first K-tile loads (discarding the previous tile), later ones add with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIDTH; r++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    r_buf[r][j] <= '0;
                end
            end
        end else if (w_rowAccept) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (r_kCnt == '0) begin
                    r_buf[r_rowCnt][j] <= w_ext[j];
                end else begin
                    r_buf[r_rowCnt][j] <= r_buf[r_rowCnt][j] + w_ext[j];
                end
            end
        end
    end

endmodule
